// File: rtl/time_countdown.sv
// Seconds countdown timer with run/pause control and a 1 s prescaler.
// Build option: define TIME_COUNTDOWN_AUTO_RELOAD_EN to auto-reload at zero.
//
// Ports:
//   clk       system clock, rising edge
//   rst       async active-low reset
//   load      load request, Time <= load_val, go IDLE
//   load_val  seconds to load
//   start     begin (IDLE) or resume (PAUSE) counting
//   pause     suspend counting (RUN only)
//   Time      remaining seconds (registered)
//   running   high in RUN
//   done      one-cycle pulse when a count reaches 0
//   expired   high in EXPIRED
module time_countdown #(
  parameter int CLK_HZ = 100000000,
  parameter int W      = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         start,
  input  logic         pause,
  output logic [W-1:0] Time,
  output logic         running,
  output logic         done,
  output logic         expired
);

  localparam int PW = $clog2(CLK_HZ);
  localparam logic [PW-1:0] PTC = PW'(CLK_HZ - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_PAUSE,
    S_EXP
  } state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  time_q, time_d;
  logic [W-1:0]  reload_q, reload_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          done_q, done_d;
  logic          tick;

  assign tick = (presc_q == PTC);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      time_q   <= '0;
      reload_q <= '0;
      presc_q  <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      time_q   <= time_d;
      reload_q <= reload_d;
      presc_q  <= presc_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    time_d   = time_q;
    reload_d = reload_q;
    presc_d  = presc_q;
    done_d   = 1'b0;
    if (load) begin
      time_d   = load_val;
      reload_d = load_val;
      presc_d  = '0;
      state_d  = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          // pause outranks start even though it has no effect here
          if (!pause && start && time_q != '0) begin
            state_d = S_RUN;
            presc_d = '0;
          end
        end
        S_RUN: begin
          presc_d = tick ? '0 : presc_q + PW'(1);
          if (tick) begin
            if (time_q > W'(1)) begin
              time_d = time_q - W'(1);
            end else if (time_q == W'(1)) begin
              done_d = 1'b1;
`ifdef TIME_COUNTDOWN_AUTO_RELOAD_EN
              time_d = reload_q;
              if (reload_q == '0) begin
                state_d = S_EXP;
              end
`else
              time_d  = '0;
              state_d = S_EXP;
`endif
            end
          end
          // a pause on the final tick loses to expiry
          if (pause && state_d != S_EXP) begin
            state_d = S_PAUSE;
          end
        end
        S_PAUSE: begin
          // prescaler is held, so the partial second resumes intact
          if (!pause && start) begin
            state_d = S_RUN;
          end
        end
        S_EXP: begin
          state_d = S_EXP;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  assign Time    = time_q;
  assign done    = done_q;
  assign running = (state_q == S_RUN);
  assign expired = (state_q == S_EXP);

endmodule

// File: tb/tb_time_countdown.sv
// Directed bench for time_countdown at CLK_HZ=4, W=16.
// Expected values are hand-derived cycle by cycle.
module tb_time_countdown;

  logic        clk;
  logic        rst;
  logic        load;
  logic [15:0] load_val;
  logic        start;
  logic        pause;
  logic [15:0] Time;
  logic        running;
  logic        done;
  logic        expired;

  int errors = 0;
  int checks = 0;

  time_countdown #(
    .CLK_HZ(4),
    .W(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .load(load),
    .load_val(load_val),
    .start(start),
    .pause(pause),
    .Time(Time),
    .running(running),
    .done(done),
    .expired(expired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic st(input string tag, input logic [15:0] t,
                    input logic r, input logic d, input logic e);
    chk({tag, ".Time"}, 32'(Time), 32'(t));
    chk({tag, ".running"}, 32'(running), 32'(r));
    chk({tag, ".done"}, 32'(done), 32'(d));
    chk({tag, ".expired"}, 32'(expired), 32'(e));
  endtask

  task automatic do_load(input logic [15:0] v);
    load = 1'b1;
    load_val = v;
    cyc(1);
    load = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    cyc(1);
    start = 1'b0;
  endtask

  task automatic do_pause();
    pause = 1'b1;
    cyc(1);
    pause = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    load = 1'b0;
    load_val = '0;
    start = 1'b0;
    pause = 1'b0;
    #3;
    st("reset", 16'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    cyc(1);
    st("post_reset", 16'd0, 1'b0, 1'b0, 1'b0);

    // basic countdown 3 -> 0
    do_load(16'd3);
    st("load3", 16'd3, 1'b0, 1'b0, 1'b0);
    do_start();
    st("start3", 16'd3, 1'b1, 1'b0, 1'b0);
    cyc(3);
    st("run3_c3", 16'd3, 1'b1, 1'b0, 1'b0);
    cyc(1);
    st("run3_t1", 16'd2, 1'b1, 1'b0, 1'b0);
    cyc(4);
    st("run3_t2", 16'd1, 1'b1, 1'b0, 1'b0);
    cyc(3);
    st("run3_pre0", 16'd1, 1'b1, 1'b0, 1'b0);
    cyc(1);
`ifdef TIME_COUNTDOWN_AUTO_RELOAD_EN
    st("run3_reload", 16'd3, 1'b1, 1'b1, 1'b0);
    cyc(1);
    st("run3_after", 16'd3, 1'b1, 1'b0, 1'b0);
`else
    st("run3_zero", 16'd0, 1'b0, 1'b1, 1'b1);
    cyc(1);
    st("run3_after", 16'd0, 1'b0, 1'b0, 1'b1);
    do_start();
    st("exp_start", 16'd0, 1'b0, 1'b0, 1'b1);
    do_pause();
    st("exp_pause", 16'd0, 1'b0, 1'b0, 1'b1);
    cyc(5);
    st("exp_hold", 16'd0, 1'b0, 1'b0, 1'b1);
`endif

    // pause/resume keeps the partial second
    do_load(16'd5);
    st("load5", 16'd5, 1'b0, 1'b0, 1'b0);
    do_start();
    cyc(1);
    do_pause();
    st("paused", 16'd5, 1'b0, 1'b0, 1'b0);
    cyc(10);
    st("pause_hold", 16'd5, 1'b0, 1'b0, 1'b0);
    do_start();
    st("resume", 16'd5, 1'b1, 1'b0, 1'b0);
    cyc(1);
    st("resume_c1", 16'd5, 1'b1, 1'b0, 1'b0);
    cyc(1);
    st("resume_c2", 16'd4, 1'b1, 1'b0, 1'b0);

    // pause+start in RUN -> PAUSE
    pause = 1'b1;
    start = 1'b1;
    cyc(1);
    pause = 1'b0;
    start = 1'b0;
    st("ps_run", 16'd4, 1'b0, 1'b0, 1'b0);
    cyc(4);
    st("ps_hold", 16'd4, 1'b0, 1'b0, 1'b0);
    // load+pause+start -> IDLE with new value
    load = 1'b1;
    load_val = 16'd7;
    pause = 1'b1;
    start = 1'b1;
    cyc(1);
    load = 1'b0;
    pause = 1'b0;
    start = 1'b0;
    st("lps", 16'd7, 1'b0, 1'b0, 1'b0);
    do_pause();
    st("idle_pause", 16'd7, 1'b0, 1'b0, 1'b0);

    // pause coinciding with a tick: decrement then pause
    do_start();
    cyc(3);
    do_pause();
    st("pause_tick", 16'd6, 1'b0, 1'b0, 1'b0);
    do_start();
    cyc(3);
    st("pt_resume3", 16'd6, 1'b1, 1'b0, 1'b0);
    cyc(1);
    st("pt_resume4", 16'd5, 1'b1, 1'b0, 1'b0);

`ifndef TIME_COUNTDOWN_AUTO_RELOAD_EN
    // pause on the final tick: expiry wins
    do_load(16'd1);
    do_start();
    cyc(3);
    do_pause();
    st("pause_last", 16'd0, 1'b0, 1'b1, 1'b1);
`endif

    // zero load: start ignored
    do_load(16'd0);
    do_start();
    st("zero_start", 16'd0, 1'b0, 1'b0, 1'b0);
    cyc(5);
    st("zero_hold", 16'd0, 1'b0, 1'b0, 1'b0);

    // asynchronous reset mid-count
    do_load(16'd9);
    do_start();
    cyc(2);
    #2;
    rst = 1'b0;
    #1;
    st("async_rst", 16'd0, 1'b0, 1'b0, 1'b0);
    cyc(1);
    st("rst_held", 16'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    cyc(1);
    st("rst_rel", 16'd0, 1'b0, 1'b0, 1'b0);
    do_load(16'd2);
    do_start();
    cyc(3);
    st("rst_first3", 16'd2, 1'b1, 1'b0, 1'b0);
    cyc(1);
    st("rst_tick", 16'd1, 1'b1, 1'b0, 1'b0);

`ifdef TIME_COUNTDOWN_AUTO_RELOAD_EN
    // auto reload: 2,1,2,1 with done every 8 cycles
    do_load(16'd2);
    do_start();
    cyc(4);
    st("ar_1", 16'd1, 1'b1, 1'b0, 1'b0);
    cyc(4);
    st("ar_2", 16'd2, 1'b1, 1'b1, 1'b0);
    cyc(1);
    st("ar_2b", 16'd2, 1'b1, 1'b0, 1'b0);
    cyc(3);
    st("ar_3", 16'd1, 1'b1, 1'b0, 1'b0);
    cyc(4);
    st("ar_4", 16'd2, 1'b1, 1'b1, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/time_countdown.md
TIME_COUNTDOWN -- requirements
Module: time_countdown

Interface
REQ-001 SHALL have parameter CLK_HZ, default 100000000, clock cycles per one-second tick (>=2).
REQ-002 SHALL have parameter W, default 16, width of the seconds value.
REQ-003 SHALL have port clk  input  1  single system clock, all logic on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous active-low reset (0 = reset).
REQ-005 SHALL have port load  input  1  one-cycle request to load load_val.
REQ-006 SHALL have port load_val  input  W  seconds value to load.
REQ-007 SHALL have port start  input  1  one-cycle request to begin or resume counting.
REQ-008 SHALL have port pause  input  1  one-cycle request to suspend counting.
REQ-009 SHALL have port Time  output  W  remaining seconds, registered.
REQ-010 SHALL have port running  output  1  high while state is RUN.
REQ-011 SHALL have port done  output  1  one-cycle pulse when Time reaches 0 by counting.
REQ-012 SHALL have port expired  output  1  high while state is EXPIRED.

Function
REQ-013 SHALL implement states IDLE, RUN, PAUSE, EXPIRED, with outputs registered (no combinational path from inputs to outputs).
REQ-014 SHALL keep a prescaler counting 0..CLK_HZ-1 only in RUN; terminal count (CLK_HZ-1) SHALL wrap to 0 and produce one internal tick.
REQ-015 SHALL, on a tick in RUN with Time>1, decrement Time by 1 in the same edge.
REQ-016 SHALL, on a tick in RUN with Time==1, set Time to 0, assert done for exactly one cycle, and enter EXPIRED (see REQ-027 for reload build).
REQ-017 SHALL, on load in any state, set Time=load_val, store load_val in a reload register, clear prescaler, deassert done, and enter IDLE.
REQ-018 SHALL, on start in IDLE with Time!=0, enter RUN with prescaler at 0; start with Time==0 SHALL be ignored.
REQ-019 SHALL, on pause in RUN, enter PAUSE holding Time and the prescaler value; pause in any other state SHALL be ignored.
REQ-020 SHALL, on start in PAUSE, return to RUN resuming the held prescaler value (no lost or extra partial second).
REQ-021 SHALL ignore start and pause in EXPIRED; only load or reset leaves EXPIRED.
REQ-022 SHALL apply input priority load > pause > start when asserted in the same cycle.
REQ-023 SHALL, when pause coincides with a tick in RUN, perform the decrement (and done/expiry if Time==1) and then honour pause only if the result state is not EXPIRED.
REQ-024 SHALL never decrement Time below 0 and never wrap Time from 0 to 2^W-1.

Reset
REQ-025 SHALL, while rst==0, asynchronously force state=IDLE, Time=0, reload register=0, prescaler=0, running=0, done=0, expired=0.
REQ-026 SHALL resume normal operation on the first rising clk edge after rst deasserts, with no tick within the first CLK_HZ cycles of RUN; reset mid-RUN SHALL discard the partial second.

Configuration
REQ-027 SHALL support macro TIME_COUNTDOWN_AUTO_RELOAD_EN: when defined, on the REQ-016 event Time SHALL be reloaded from the reload register in the same edge, done pulses, state stays RUN (EXPIRED entered only if reload value is 0); when undefined, REQ-016 applies unchanged and reload register is unused for counting.

Verification (CLK_HZ=4, W=16)
REQ-028 SHALL cover: reset, load 3, start -> Time 3->2->1->0 at 4-cycle intervals, done high exactly 1 cycle at 0, expired=1, running=0.
REQ-029 SHALL cover: load 5, start, pause after 2 cycles, hold 10 cycles, start -> Time unchanged during pause, first decrement 2 cycles after resume.
REQ-030 SHALL cover: load, start, pause and start asserted together in RUN -> PAUSE; load+pause+start together -> IDLE with Time=load_val.
REQ-031 SHALL cover: load 0, start -> state stays IDLE, running=0, done never asserted; start in EXPIRED -> ignored.
REQ-032 SHALL cover: rst pulsed low mid-count (asynchronous, between edges) -> all outputs 0 immediately, IDLE after release.
REQ-033 SHALL cover, with TIME_COUNTDOWN_AUTO_RELOAD_EN: load 2, start -> Time 2,1,2,1,... with done pulse every 8 cycles, expired never asserted.
